pieo_dequeue_ctrl: RTL and testbench

PIEO_DEQUEUE_CTRL -- requirements
Module: pieo_dequeue_ctrl

---
 rtl/pieo_dequeue_ctrl.sv | 155 +++++++++++++++
 tb/tb_pieo_dequeue_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pieo_dequeue_ctrl.sv
// pieo_dequeue_ctrl
// Issues one-at-a-time dequeue requests to a PIEO and holds each returned
// element until the downstream consumer accepts it. Empty responses trigger a
// short backoff. Missing responses trigger a timeout. Stray responses set a
// sticky flag. A free-running time base stamps each request with the current
// time and measures the lateness of each returned element.
module pieo_dequeue_ctrl #(
  parameter int ID_LOG    = 4,
  parameter int RANK_LOG  = 4,
  parameter int TIME_LOG  = 16,
  parameter int RETRY_GAP = 2,
  parameter int MAX_WAIT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                deq_req,
  output logic [TIME_LOG-1:0] deq_time,
  input  logic                deq_resp_valid,
  input  logic                deq_resp_found,
  input  logic [ID_LOG-1:0]   deq_resp_id,
  input  logic [RANK_LOG-1:0] deq_resp_rank,
  input  logic [TIME_LOG-1:0] deq_resp_send_time,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_LOG-1:0]   out_id,
  output logic [RANK_LOG-1:0] out_rank,
  output logic [TIME_LOG-1:0] out_send_time,
  output logic [TIME_LOG-1:0] out_lateness,
  output logic [TIME_LOG-1:0] now,
  output logic [15:0]         deq_count,
  output logic [15:0]         miss_count,
  output logic                err_timeout,
  output logic                err_unexpected
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_BACKOFF
  } state_t;

  state_t              state_reg;
  logic [3:0]          backoff_cnt_reg;
  logic [7:0]          wait_cnt_reg;
  logic [1:0]          arm_reg;
  logic [TIME_LOG-1:0] now_next;

  // deq_time is registered on the edge that enters REQ, so it takes the value
  // that now will hold during the REQ cycle.
  assign now_next = now + TIME_LOG'(1);

  // Free-running time base, wraps naturally at 2^TIME_LOG.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) now <= '0;
    else     now <= now_next;
  end

  // Two-edge guard after reset release, so that no request follows reset too closely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) arm_reg <= 2'b00;
    else     arm_reg <= {arm_reg[0], 1'b1};
  end

  // Dequeue FSM with registered outputs, counters and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      backoff_cnt_reg <= '0;
      wait_cnt_reg    <= '0;
      deq_req         <= 1'b0;
      deq_time        <= '0;
      out_valid       <= 1'b0;
      out_id          <= '0;
      out_rank        <= '0;
      out_send_time   <= '0;
      out_lateness    <= '0;
      deq_count       <= '0;
      miss_count      <= '0;
      err_timeout     <= 1'b0;
      err_unexpected  <= 1'b0;
    end else begin
      deq_req <= 1'b0;
      // A response is legal only while a request is outstanding.
      if (deq_resp_valid && (state_reg != ST_WAIT)) err_unexpected <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (enable && arm_reg[1]) begin
            state_reg <= ST_REQ;
            deq_req   <= 1'b1;
            deq_time  <= now_next;
          end
        end

        ST_REQ: begin
          state_reg    <= ST_WAIT;
          wait_cnt_reg <= '0;
        end

        ST_WAIT: begin
          if (deq_resp_valid) begin
            if (deq_resp_found) begin
              out_id        <= deq_resp_id;
              out_rank      <= deq_resp_rank;
              out_send_time <= deq_resp_send_time;
              out_lateness  <= now - deq_resp_send_time;
              out_valid     <= 1'b1;
              state_reg     <= ST_HOLD;
            end else begin
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
              backoff_cnt_reg <= 4'(RETRY_GAP);
              state_reg       <= ST_BACKOFF;
            end
          end else if (wait_cnt_reg == 8'(MAX_WAIT - 1)) begin
            err_timeout <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            deq_count <= deq_count + 16'd1;
            if (enable) begin
              state_reg <= ST_REQ;
              deq_req   <= 1'b1;
              deq_time  <= now_next;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end

        ST_BACKOFF: begin
          // The counter hits zero on the edge that leaves BACKOFF. This gives
          // RETRY_GAP backoff cycles.
          if (backoff_cnt_reg <= 4'd1) begin
            backoff_cnt_reg <= '0;
            state_reg       <= ST_IDLE;
          end else begin
            backoff_cnt_reg <= backoff_cnt_reg - 4'd1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pieo_dequeue_ctrl.sv
// tb_pieo_dequeue_ctrl
// Randomised and directed bench. A PIEO responder process answers requests and
// pushes each expected delivered element into a scoreboard queue. A monitor
// process pops the queue on each output handshake and compares the element. It
// also tracks time, counters, errors and request spacing against a reference model.
`timescale 1ns/1ps
module tb_pieo_dequeue_ctrl;

  localparam int ID_LOG    = 4;
  localparam int RANK_LOG  = 4;
  localparam int TIME_LOG  = 16;
  localparam int RETRY_GAP = 2;
  localparam int MAX_WAIT  = 15;

  localparam int M_NONE   = 0;
  localparam int M_FOUND1 = 1;
  localparam int M_MISS1  = 2;
  localparam int M_RANDOM = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic                deq_req;
  logic [TIME_LOG-1:0] deq_time;
  logic                deq_resp_valid = 1'b0;
  logic                deq_resp_found = 1'b0;
  logic [ID_LOG-1:0]   deq_resp_id = '0;
  logic [RANK_LOG-1:0] deq_resp_rank = '0;
  logic [TIME_LOG-1:0] deq_resp_send_time = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ID_LOG-1:0]   out_id;
  logic [RANK_LOG-1:0] out_rank;
  logic [TIME_LOG-1:0] out_send_time;
  logic [TIME_LOG-1:0] out_lateness;
  logic [TIME_LOG-1:0] now;
  logic [15:0]         deq_count;
  logic [15:0]         miss_count;
  logic                err_timeout;
  logic                err_unexpected;

  pieo_dequeue_ctrl #(
    .ID_LOG(ID_LOG), .RANK_LOG(RANK_LOG), .TIME_LOG(TIME_LOG),
    .RETRY_GAP(RETRY_GAP), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .deq_req(deq_req), .deq_time(deq_time),
    .deq_resp_valid(deq_resp_valid), .deq_resp_found(deq_resp_found),
    .deq_resp_id(deq_resp_id), .deq_resp_rank(deq_resp_rank),
    .deq_resp_send_time(deq_resp_send_time),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_rank(out_rank), .out_send_time(out_send_time),
    .out_lateness(out_lateness), .now(now),
    .deq_count(deq_count), .miss_count(miss_count),
    .err_timeout(err_timeout), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [ID_LOG-1:0]   id;
    logic [RANK_LOG-1:0] rank;
    logic [TIME_LOG-1:0] st;
    logic [TIME_LOG-1:0] lat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   deq_exp = 0;
  int   miss_exp = 0;
  logic err_to_exp = 1'b0;
  logic err_un_exp = 1'b0;
  int   spacing_exp = 0;
  int   resp_mode = M_NONE;
  logic resp_legit = 1'b0;
  logic [ID_LOG-1:0]   fix_id = '0;
  logic [RANK_LOG-1:0] fix_rank = '0;
  logic [TIME_LOG-1:0] fix_lat = '0;
  logic [TIME_LOG-1:0] now_model;

  // Reference time: counts clock edges since reset.
  always @(posedge clk or posedge rst) begin
    if (rst) now_model <= '0;
    else     now_model <= now_model + 16'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired, got timeout, expected event (t=%0t)", name, $time);
  endtask

  task automatic wait_deq_req(input int max);
    int n;
    n = 0;
    while (deq_req !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (deq_req !== 1'b1) bound_fail("wait_deq_req");
  endtask

  task automatic wait_out_valid(input int max);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) bound_fail("wait_out_valid");
  endtask

  // ---------------- PIEO responder ----------------
  initial begin
    int   dly;
    logic fnd;
    logic [ID_LOG-1:0]   r_id;
    logic [RANK_LOG-1:0] r_rank;
    logic [TIME_LOG-1:0] r_lat;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && deq_req === 1'b1 && resp_mode != M_NONE) begin
        if (resp_mode == M_RANDOM) begin
          dly    = $urandom_range(1, 4);
          fnd    = ($urandom_range(0, 9) < 7);
          r_id   = ID_LOG'($urandom_range(0, 15));
          r_rank = RANK_LOG'($urandom_range(0, 15));
          r_lat  = TIME_LOG'($urandom_range(0, 1000));
        end else begin
          dly    = 1;
          fnd    = (resp_mode == M_FOUND1);
          r_id   = fix_id;
          r_rank = fix_rank;
          r_lat  = fix_lat;
        end
        @(negedge clk);
        repeat (dly - 1) @(negedge clk);
        deq_resp_valid     = 1'b1;
        deq_resp_found     = fnd;
        deq_resp_id        = r_id;
        deq_resp_rank      = r_rank;
        deq_resp_send_time = now_model - r_lat;
        resp_legit         = 1'b1;
        if (fnd) begin
          e.id   = r_id;
          e.rank = r_rank;
          e.st   = now_model - r_lat;
          e.lat  = r_lat;
          exp_q.push_back(e);
        end
        @(negedge clk);
        deq_resp_valid = 1'b0;
        deq_resp_found = 1'b0;
        resp_legit     = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int cyc;
    int last_req;
    int prev_spacing;
    exp_t e;
    cyc = 0;
    last_req = -1;
    prev_spacing = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) continue;
      if (spacing_exp != prev_spacing) begin
        last_req = -1;
        prev_spacing = spacing_exp;
      end
      chk("now", 32'(now), 32'(now_model));
      chk("deq_count", 32'(deq_count), 32'(deq_exp));
      chk("miss_count", 32'(miss_count), 32'(miss_exp));
      chk("err_timeout", 32'(err_timeout), 32'(err_to_exp));
      chk("err_unexpected", 32'(err_unexpected), 32'(err_un_exp));
      if (deq_req === 1'b1) begin
        chk("deq_time", 32'(deq_time), 32'(now_model));
        if (spacing_exp != 0 && last_req >= 0)
          chk("req_spacing", 32'(cyc - last_req), 32'(spacing_exp));
        last_req = cyc;
      end
      if (out_valid === 1'b1) begin
        chk("no_req_in_hold", 32'(deq_req), 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: got out_valid with id %0h, expected no element", out_id);
        end else begin
          e = exp_q[0];
          chk("out_id", 32'(out_id), 32'(e.id));
          chk("out_rank", 32'(out_rank), 32'(e.rank));
          chk("out_send_time", 32'(out_send_time), 32'(e.st));
          chk("out_lateness", 32'(out_lateness), 32'(e.lat));
          if (out_ready === 1'b1) begin
            $display("deliver id=%0h rank=%0h send_time=%0h lateness=%0d", out_id, out_rank,
                     out_send_time, out_lateness);
            void'(exp_q.pop_front());
            deq_exp++;
          end
        end
      end
      if (deq_resp_valid && resp_legit && !deq_resp_found) miss_exp++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_deq_req", 32'(deq_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_now", 32'(now), 32'd0);
    chk("rst_deq_count", 32'(deq_count), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic delivery: one-cycle response, consumer always ready
    fix_id = 4'd5; fix_rank = 4'd3; fix_lat = 16'd4;
    resp_mode = M_FOUND1; out_ready = 1'b1; spacing_exp = 3; enable = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0; spacing_exp = 0;
    repeat (8) @(negedge clk);

    // Empty responses: request, wait, RETRY_GAP backoff, idle
    resp_mode = M_MISS1; spacing_exp = RETRY_GAP + 3; enable = 1'b1;
    repeat (40) @(negedge clk);
    enable = 1'b0; spacing_exp = 0;
    repeat (10) @(negedge clk);

    // Backpressure: hold for 10 cycles, then one handshake
    fix_id = 4'hA; fix_rank = 4'h7; fix_lat = 16'd33;
    resp_mode = M_FOUND1; out_ready = 1'b0; enable = 1'b1;
    wait_deq_req(20);
    enable = 1'b0;
    wait_out_valid(20);
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);

    // Randomised traffic
    resp_mode = M_RANDOM;
    for (int i = 0; i < 2000; i++) begin
      enable    = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    enable = 1'b0; out_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Timeout, then a late response
    resp_mode = M_NONE; enable = 1'b1;
    wait_deq_req(20);
    enable = 1'b0;
    repeat (MAX_WAIT + 1) @(negedge clk);
    err_to_exp = 1'b1;
    repeat (2) @(negedge clk);
    deq_resp_valid = 1'b1; deq_resp_found = 1'b1; deq_resp_id = 4'h9;
    deq_resp_rank = 4'h2; deq_resp_send_time = now_model;
    @(negedge clk);
    deq_resp_valid = 1'b0; deq_resp_found = 1'b0;
    err_un_exp = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("late_out_valid", 32'(out_valid), 32'd0);

    // Reset while an element is held
    @(negedge clk);
    fix_id = 4'h6; fix_rank = 4'h1; fix_lat = 16'd7;
    resp_mode = M_FOUND1; out_ready = 1'b0; enable = 1'b1;
    wait_deq_req(20);
    enable = 1'b0;
    wait_out_valid(20);
    #3;
    rst = 1'b1;
    #1;
    chk("hrst_out_valid", 32'(out_valid), 32'd0);
    chk("hrst_out_id", 32'(out_id), 32'd0);
    chk("hrst_out_rank", 32'(out_rank), 32'd0);
    chk("hrst_out_send_time", 32'(out_send_time), 32'd0);
    chk("hrst_out_lateness", 32'(out_lateness), 32'd0);
    chk("hrst_deq_time", 32'(deq_time), 32'd0);
    chk("hrst_now", 32'(now), 32'd0);
    chk("hrst_counts", 32'({deq_count, miss_count}), 32'd0);
    chk("hrst_errors", 32'({err_timeout, err_unexpected}), 32'd0);
    exp_q.delete();
    deq_exp = 0; miss_exp = 0; err_to_exp = 1'b0; err_un_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_req1", 32'(deq_req), 32'd0);
    @(negedge clk); #1;
    chk("post_rst_req2", 32'(deq_req), 32'd0);
    out_ready = 1'b1;
    wait_deq_req(20);
    enable = 1'b0;
    repeat (10) @(negedge clk);

    // Wrap: capture at now=0xFFFE with send_time=0xFFFC
    begin
      int n;
      n = 0;
      while (now_model != 16'hFFFC && n < 70000) begin
        @(negedge clk);
        n++;
      end
      if (now_model != 16'hFFFC) bound_fail("wait_wrap_time");
    end
    fix_id = 4'hC; fix_rank = 4'hD; fix_lat = 16'd2;
    resp_mode = M_FOUND1; out_ready = 1'b1; enable = 1'b1;
    wait_deq_req(10);
    enable = 1'b0;
    wait_out_valid(10);
    #1;
    chk("wrap_lateness", 32'(out_lateness), 32'd2);
    chk("wrap_send_time", 32'(out_send_time), 32'hFFFC);
    repeat (10) @(negedge clk);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
